// File: rtl/race_pkg.sv
// Shared definitions for the per-car motion engine.
//   state_e    : update sequencer states, one pass per video frame
//   pos_t      : signed 10.6 fixed-point world coordinate
//   trig_t     : signed Q1.7 sine/cosine sample
// Also holds the heading step, LUT depth and the step scaling shift.
package race_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEER  = 3'd1,
    ST_MOVE   = 3'd2,
    ST_PROBE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  localparam int POS_W      = 16;
  localparam int FRAC       = 6;
  localparam int LUT_DEPTH  = 36;
  localparam int DEG_STEP   = 10;
  localparam int DEG_FULL   = 360;
  // speed is 1/16 px, position is 1/64 px, trig carries 2^7: 7 - 2 = 5
  localparam int STEP_SHIFT = 5;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [7:0]       trig_t;

endpackage

// File: rtl/car_physics_engine_if.sv
// Map BRAM read port (port B) between the motion engine and the track map.
//   map_addr : word address, valid while map_req is high
//   map_req  : read strobe, one cycle per probe
//   map_data : 4-bit colour index, valid one cycle after map_req
// master = engine side, slave = memory side.
interface car_physics_engine_if;
  logic [16:0] map_addr;
  logic        map_req;
  logic [3:0]  map_data;

  modport master (output map_addr, output map_req, input map_data);
  modport slave  (input map_addr, input map_req, output map_data);
endinterface

// File: rtl/heading_trig_lut.sv
// Heading to sine/cosine lookup, purely combinational.
//   degree_i : heading 0..359 in 10-degree steps, 0 = up, clockwise
//   sin_o    : round(127*sin(degree)), Q1.7
//   cos_o    : round(127*cos(degree)), Q1.7
// Cosine reuses the sine table shifted by a quarter turn.
module heading_trig_lut
  import race_pkg::*;
(
  input  logic [8:0] degree_i,
  output trig_t      sin_o,
  output trig_t      cos_o
);

  localparam logic [5:0] QUARTER  = 6'(90 / DEG_STEP);
  localparam logic [5:0] WRAP_LIM = 6'(LUT_DEPTH - 90 / DEG_STEP);

  logic [5:0] sin_idx;
  logic [5:0] cos_idx;

  function automatic trig_t sin_of(input logic [5:0] idx);
    trig_t v;
    case (idx)
      6'd0:  v = 8'sd0;
      6'd1:  v = 8'sd22;
      6'd2:  v = 8'sd43;
      6'd3:  v = 8'sd64;
      6'd4:  v = 8'sd82;
      6'd5:  v = 8'sd97;
      6'd6:  v = 8'sd110;
      6'd7:  v = 8'sd119;
      6'd8:  v = 8'sd125;
      6'd9:  v = 8'sd127;
      6'd10: v = 8'sd125;
      6'd11: v = 8'sd119;
      6'd12: v = 8'sd110;
      6'd13: v = 8'sd97;
      6'd14: v = 8'sd82;
      6'd15: v = 8'sd64;
      6'd16: v = 8'sd43;
      6'd17: v = 8'sd22;
      6'd18: v = 8'sd0;
      6'd19: v = -8'sd22;
      6'd20: v = -8'sd43;
      6'd21: v = -8'sd64;
      6'd22: v = -8'sd82;
      6'd23: v = -8'sd97;
      6'd24: v = -8'sd110;
      6'd25: v = -8'sd119;
      6'd26: v = -8'sd125;
      6'd27: v = -8'sd127;
      6'd28: v = -8'sd125;
      6'd29: v = -8'sd119;
      6'd30: v = -8'sd110;
      6'd31: v = -8'sd97;
      6'd32: v = -8'sd82;
      6'd33: v = -8'sd64;
      6'd34: v = -8'sd43;
      6'd35: v = -8'sd22;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

  always_comb begin
    sin_idx = 6'(degree_i / 9'(DEG_STEP));
    cos_idx = (sin_idx >= WRAP_LIM) ? sin_idx - WRAP_LIM : sin_idx + QUARTER;
    sin_o   = sin_of(sin_idx);
    cos_o   = sin_of(cos_idx);
  end

endmodule

// File: rtl/car_physics_engine.sv
// Per-car motion engine. Once per frame_tick it steers, accelerates,
// computes a candidate position, probes the track map and commits or
// rejects the move.
//   clk, rst                 : clock (also map port B), async active-high reset
//   frame_tick               : one-cycle frame pulse
//   btn_throttle/brake/left/right : debounced button levels
//   map_bus                  : map BRAM read port (master side)
//   world_x, world_y         : integer world position
//   degree                   : heading 0..359, clockwise, 0 = up (-y)
//   speed                    : speed in 1/16 px/frame
//   busy, done               : update in progress / commit pulse
//   collided                 : last move rejected
//   overrun                  : sticky, a tick arrived while busy
module car_physics_engine
  import race_pkg::*;
#(
  parameter int         MAP_WIDTH       = 320,
  parameter int         MAP_HEIGHT      = 240,
  parameter int         MAP_BASE        = 0,
  parameter int         START_X         = 160,
  parameter int         START_Y         = 120,
  parameter int         START_DEG       = 0,
  parameter int         MAX_SPEED       = 48,
  parameter int         GRASS_MAX_SPEED = 16,
  parameter int         ACCEL           = 2,
  parameter int         BRAKE           = 4,
  parameter int         FRICTION        = 1,
  parameter logic [3:0] GRASS_IDX       = 4'd2,
  parameter logic [3:0] WALL_IDX        = 4'd5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic                        btn_throttle,
  input  logic                        btn_brake,
  input  logic                        btn_left,
  input  logic                        btn_right,
  car_physics_engine_if.master        map_bus,
  output logic [9:0]                  world_x,
  output logic [9:0]                  world_y,
  output logic [8:0]                  degree,
  output logic [5:0]                  speed,
  output logic                        busy,
  output logic                        done,
  output logic                        collided,
  output logic                        overrun
);

  localparam logic [5:0]  SPD_MAX   = 6'(MAX_SPEED);
  localparam logic [5:0]  SPD_GRASS = 6'(GRASS_MAX_SPEED);
  localparam logic [5:0]  SPD_ACC   = 6'(ACCEL);
  localparam logic [5:0]  SPD_BRK   = 6'(BRAKE);
  localparam logic [5:0]  SPD_FRIC  = 6'(FRICTION);
  localparam logic [9:0]  MAP_W     = 10'(MAP_WIDTH);
  localparam logic [9:0]  MAP_H     = 10'(MAP_HEIGHT);
  localparam logic [16:0] ADDR_BASE = 17'(MAP_BASE);
  localparam logic [8:0]  DSTEP     = 9'(DEG_STEP);
  localparam logic [8:0]  DLAST     = 9'(DEG_FULL - DEG_STEP);
  localparam pos_t        START_PX  = pos_t'(START_X * (1 << FRAC));
  localparam pos_t        START_PY  = pos_t'(START_Y * (1 << FRAC));

  state_e      state_q, state_d;
  logic [8:0]  degree_q, degree_d;
  logic [5:0]  speed_q, speed_d;
  pos_t        pos_x_q, pos_x_d;
  pos_t        pos_y_q, pos_y_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        collided_q, collided_d;
  logic        overrun_q, overrun_d;
  logic        map_req_q, map_req_d;
  logic [16:0] map_addr_q, map_addr_d;

  // candidate pipeline registers, only meaningful inside an update
  pos_t        cand_x_q, cand_y_q;
  logic        oob_q;

  trig_t       sin_w, cos_w;
  pos_t        step_x, step_y;
  logic [9:0]  cand_xi, cand_yi;
  logic        cand_oob;
  logic [16:0] cand_addr;

  function automatic logic [8:0] steer(input logic [8:0] d, input logic l, input logic r);
    logic [8:0] res;
    res = d;
    if (l && !r)      res = (d < DSTEP)  ? d + DLAST : d - DSTEP;
    else if (r && !l) res = (d >= DLAST) ? d - DLAST : d + DSTEP;
    return res;
  endfunction

  function automatic logic [5:0] sat_sub(input logic [5:0] a, input logic [5:0] b);
    return (a < b) ? 6'd0 : a - b;
  endfunction

  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] lim);
    logic [6:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[5:0];
  endfunction

  function automatic logic [5:0] sat_min(input logic [5:0] a, input logic [5:0] lim);
    return (a > lim) ? lim : a;
  endfunction

  // speed * trig, floor-scaled down to 1/64 px
  function automatic pos_t scale_step(input logic [5:0] spd, input trig_t t);
    pos_t prod;
    prod = pos_t'({10'd0, spd}) * pos_t'(t);
    return prod >>> STEP_SHIFT;
  endfunction

  heading_trig_lut u_trig (
    .degree_i (degree_q),
    .sin_o    (sin_w),
    .cos_o    (cos_w)
  );

  always_comb begin
    step_x    = scale_step(speed_q, sin_w);
    step_y    = -scale_step(speed_q, cos_w);
    cand_xi   = cand_x_q[POS_W-1:FRAC];
    cand_yi   = cand_y_q[POS_W-1:FRAC];
    cand_oob  = cand_x_q[POS_W-1] | cand_y_q[POS_W-1] |
                (cand_xi >= MAP_W) | (cand_yi >= MAP_H);
    // row stride 320 = 256 + 64
    cand_addr = ADDR_BASE + ({7'd0, cand_yi} << 8) + ({7'd0, cand_yi} << 6) +
                {7'd0, cand_xi};
  end

  always_comb begin
    state_d    = state_q;
    degree_d   = degree_q;
    speed_d    = speed_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    collided_d = collided_q;
    done_d     = 1'b0;
    map_req_d  = 1'b0;
    map_addr_d = map_addr_q;
    overrun_d  = overrun_q | (frame_tick && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick) state_d = ST_STEER;
      end
      ST_STEER: begin
        state_d  = ST_MOVE;
        degree_d = steer(degree_q, btn_left, btn_right);
        if (btn_brake)         speed_d = sat_sub(speed_q, SPD_BRK);
        else if (btn_throttle) speed_d = sat_add(speed_q, SPD_ACC, SPD_MAX);
        else                   speed_d = sat_sub(speed_q, SPD_FRIC);
      end
      ST_MOVE: begin
        state_d = ST_PROBE;
      end
      ST_PROBE: begin
        state_d   = ST_WAIT;
        map_req_d = !cand_oob;
        if (!cand_oob) map_addr_d = cand_addr;
      end
      ST_WAIT: begin
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (oob_q || (map_bus.map_data == WALL_IDX)) begin
          speed_d    = 6'd0;
          collided_d = 1'b1;
        end else begin
          pos_x_d    = cand_x_q;
          pos_y_d    = cand_y_q;
          collided_d = 1'b0;
          if (map_bus.map_data == GRASS_IDX) speed_d = sat_min(speed_q, SPD_GRASS);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = state_d inside {ST_MOVE, ST_PROBE, ST_WAIT, ST_COMMIT};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      degree_q   <= 9'(START_DEG);
      speed_q    <= 6'd0;
      pos_x_q    <= START_PX;
      pos_y_q    <= START_PY;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      collided_q <= 1'b0;
      overrun_q  <= 1'b0;
      map_req_q  <= 1'b0;
      map_addr_q <= 17'd0;
    end else begin
      state_q    <= state_d;
      degree_q   <= degree_d;
      speed_q    <= speed_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      collided_q <= collided_d;
      overrun_q  <= overrun_d;
      map_req_q  <= map_req_d;
      map_addr_q <= map_addr_d;
    end
  end

  // MOVE -> PROBE: latch candidate; PROBE -> WAIT: latch bounds verdict
  always_ff @(posedge clk) begin
    if (state_q == ST_MOVE) begin
      cand_x_q <= pos_x_q + step_x;
      cand_y_q <= pos_y_q + step_y;
    end
    if (state_q == ST_PROBE) oob_q <= cand_oob;
  end

  assign world_x          = pos_x_q[POS_W-1:FRAC];
  assign world_y          = pos_y_q[POS_W-1:FRAC];
  assign degree           = degree_q;
  assign speed            = speed_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign collided         = collided_q;
  assign overrun          = overrun_q;
  assign map_bus.map_addr = map_addr_q;
  assign map_bus.map_req  = map_req_q;

endmodule

// File: tb/tb_car_physics_engine.sv
module tb_car_physics_engine;

  localparam int MAPW = 320, MAPH = 240;
  localparam int MAXS = 48, GRASSS = 16, ACC = 2, BRK = 4, FRIC = 1;
  localparam int WALL = 5, GRASS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_throttle, btn_brake, btn_left, btn_right;
  logic [9:0] world_x, world_y;
  logic [8:0] degree;
  logic [5:0] speed;
  logic       busy, done, collided, overrun;
  logic [3:0] colour;

  int tests_run = 0;
  int tests_failed = 0;
  int req_cnt = 0;

  // reference model state (position in 1/64 px)
  int m_px, m_py, m_deg, m_spd;
  bit m_col, m_ovr;
  int e_deg, e_spd, e_addr;
  bit e_inb;

  car_physics_engine_if map_bus ();

  car_physics_engine dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .btn_throttle (btn_throttle),
    .btn_brake    (btn_brake),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .map_bus      (map_bus),
    .world_x      (world_x),
    .world_y      (world_y),
    .degree       (degree),
    .speed        (speed),
    .busy         (busy),
    .done         (done),
    .collided     (collided),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // one-cycle-latency map BRAM returning the colour chosen for this frame
  always @(posedge clk) begin
    if (rst) map_bus.map_data <= 4'd0;
    else if (map_bus.map_req) begin
      map_bus.map_data <= colour;
      req_cnt          <= req_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_trig(input int d, input bit is_cos);
    real a, r;
    a = real'(d + (is_cos ? 90 : 0)) * 3.14159265358979 / 180.0;
    r = 127.0 * $sin(a);
    if (r >= 0.0) return $rtoi(r + 0.5 + 1.0e-6);
    else          return -$rtoi(-r + 0.5 + 1.0e-6);
  endfunction

  task automatic model_reset();
    m_px = 160 * 64; m_py = 120 * 64; m_deg = 0; m_spd = 0; m_col = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit t, input bit b,
                            input logic [3:0] col);
    int cx, cy;
    if (l && !r)      m_deg = (m_deg + 350) % 360;
    else if (r && !l) m_deg = (m_deg + 10) % 360;
    if (b)      m_spd = (m_spd > BRK) ? m_spd - BRK : 0;
    else if (t) m_spd = (m_spd + ACC > MAXS) ? MAXS : m_spd + ACC;
    else        m_spd = (m_spd > FRIC) ? m_spd - FRIC : 0;
    e_deg = m_deg;
    e_spd = m_spd;
    cx = m_px + ((m_spd * ref_trig(m_deg, 0)) >>> 5);
    cy = m_py - ((m_spd * ref_trig(m_deg, 1)) >>> 5);
    e_inb  = (cx >= 0) && (cy >= 0) && (cx / 64 < MAPW) && (cy / 64 < MAPH);
    e_addr = (cy / 64) * 320 + cx / 64;
    if (!e_inb || col == 4'(WALL)) begin
      m_spd = 0; m_col = 1;
    end else begin
      m_px = cx; m_py = cy; m_col = 0;
      if (col == 4'(GRASS) && m_spd > GRASSS) m_spd = GRASSS;
    end
  endtask

  task automatic reset_dut();
    frame_tick = 0; btn_throttle = 0; btn_brake = 0; btn_left = 0; btn_right = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input bit l, input bit r, input bit t, input bit b,
                           input logic [3:0] col, input bit extra_tick);
    int base_req, lat;
    btn_left = l; btn_right = r; btn_throttle = t; btn_brake = b; colour = col;
    model_step(l, r, t, b, col);
    if (extra_tick) m_ovr = 1;
    base_req = req_cnt;
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        check("steer_degree", degree, e_deg);
        check("steer_speed", speed, e_spd);
        check("busy_high", busy, 1);
      end
      if (c == 2 && extra_tick) frame_tick = 1;
      if (c == 3) begin
        frame_tick = 0;
        check("map_req", map_bus.map_req, e_inb);
        if (e_inb) check("map_addr", map_bus.map_addr, e_addr);
      end
      if (c == 4) check("map_req_drop", map_bus.map_req, 0);
      if (done === 1'b1) begin lat = c; break; end
    end
    check("latency", lat, 5);
    check("world_x", world_x, m_px / 64);
    check("world_y", world_y, m_py / 64);
    check("speed", speed, m_spd);
    check("collided", collided, m_col);
    check("overrun", overrun, m_ovr);
    check("busy_low", busy, 0);
    check("req_count", req_cnt - base_req, e_inb ? 1 : 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
  endtask

  initial begin
    int sx, sy, seen_done;
    logic [3:0] pal [5];
    pal[0] = 4'd0; pal[1] = 4'd1; pal[2] = 4'd2; pal[3] = 4'd5; pal[4] = 4'd7;
    rst = 0; colour = 0;
    frame_tick = 0; btn_throttle = 0; btn_brake = 0; btn_left = 0; btn_right = 0;
    #2;
    reset_dut();

    check("rst_world_x", world_x, 160);
    check("rst_world_y", world_y, 120);
    check("rst_degree", degree, 0);
    check("rst_speed", speed, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_collided", collided, 0);
    check("rst_overrun", overrun, 0);
    check("rst_map_req", map_bus.map_req, 0);
    check("rst_map_addr", map_bus.map_addr, 0);

    // throttle from rest heading up
    run_frame(0, 0, 1, 0, 4'd0, 0);
    check("thr_speed", speed, 2);
    check("thr_world_y", world_y, 119);
    check("thr_world_x", world_x, 160);

    // steering wrap and cancel
    run_frame(1, 0, 0, 0, 4'd0, 0);
    check("left_wrap", degree, 350);
    run_frame(0, 1, 0, 0, 4'd0, 0);
    check("right_wrap", degree, 0);
    run_frame(1, 1, 0, 0, 4'd0, 0);
    check("both_hold", degree, 0);

    // wall hit at speed 20
    for (int i = 0; i < 40 && m_spd < 18; i++) run_frame(0, 0, 1, 0, 4'd0, 0);
    sx = world_x; sy = world_y;
    run_frame(0, 0, 1, 0, 4'(WALL), 0);
    check("wall_speed", speed, 0);
    check("wall_collided", collided, 1);
    check("wall_x_kept", world_x, sx);
    check("wall_y_kept", world_y, sy);

    // grass clamp from speed 40
    for (int i = 0; i < 40 && m_spd < 38; i++) run_frame(0, 0, 1, 0, 4'd0, 0);
    run_frame(0, 0, 1, 0, 4'(GRASS), 0);
    check("grass_speed", speed, 16);
    check("grass_collided", collided, 0);

    // tick while busy
    run_frame(0, 0, 1, 0, 4'd0, 1);
    check("overrun_set", overrun, 1);

    // randomized frames against the model
    for (int i = 0; i < 150; i++)
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                pal[$urandom_range(0, 4)], 0);

    // asynchronous reset while waiting on the map read
    btn_throttle = 1; colour = 4'd0;
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_world_x", world_x, 160);
    check("mid_rst_world_y", world_y, 120);
    check("mid_rst_degree", degree, 0);
    check("mid_rst_speed", speed, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_collided", collided, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_map_req", map_bus.map_req, 0);
    check("mid_rst_map_addr", map_bus.map_addr, 0);
    @(negedge clk);
    rst = 1'b0; btn_throttle = 0;
    model_reset();
    seen_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1;
    end
    check("mid_rst_no_done", seen_done, 0);
    check("mid_rst_idle_busy", busy, 0);

    // drive east into the right map edge
    for (int i = 0; i < 9; i++) run_frame(0, 1, 0, 0, 4'd0, 0);
    check("bnd_degree", degree, 90);
    sx = world_x; sy = world_y;
    for (int i = 0; i < 200; i++) begin
      sx = world_x; sy = world_y;
      run_frame(0, 0, 1, 0, 4'd0, 0);
      if (!e_inb) break;
    end
    check("bnd_oob_reached", e_inb, 0);
    check("bnd_near_edge", (sx >= 317), 1);
    check("bnd_collided", collided, 1);
    check("bnd_x_kept", world_x, sx);
    check("bnd_y_kept", world_y, sy);
    check("bnd_speed", speed, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
